calc_issuer: RTL and testbench
==============================

Name: calc_issuer

Overview:
Operand issuer and result collector for the pipelined arithmetic core, which computes q = ((a-b)*(3c+1) - 4d) >>> 1.
- Upstream side: accepts operand sets {a,b,c,d} on a valid/ready stream.
- Core side: drives the core's a/b/c/d data and valid inputs, and captures its q/q_valid output.
- Downstream side: presents results in issue order on a valid/ready stream.
- The core has no backpressure, so the block uses credit-based issue to guarantee a result slot for every operation in flight.

Parameters:
DATA_WIDTH, 32, width of operands and result (matches core).
RES_DEPTH, 8, result FIFO depth; power of two, >= 2.
CORE_LATENCY, 3, cycles from core valid inputs to core q_valid; used only by CALC_ISSUER_CHECK_EN.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset.
s_valid_i  in  1  upstream operand set valid.
s_ready_o  out  1  upstream ready.
s_a_i, s_b_i, s_c_i, s_d_i  in  DATA_WIDTH each  signed upstream operands.
a_o, b_o, c_o, d_o  out  DATA_WIDTH each  signed operands to core.
a_valid_o, b_valid_o, c_valid_o, d_valid_o  out  1 each  operand valids to core.
q_i  in  DATA_WIDTH  signed core result.
q_valid_i  in  1  core result valid.
m_valid_o  out  1  downstream result valid.
m_ready_i  in  1  downstream ready.
m_q_o  out  DATA_WIDTH  signed result (FIFO head).
inflight_o  out  $clog2(RES_DEPTH+1)  operations issued but not yet returned.
unexpected_o  out  1  sticky: q_valid_i seen while inflight==0.
mismatch_o  out  1  sticky: result differs from expected (CALC_ISSUER_CHECK_EN only; tied 0 otherwise).

Behaviour:
Clock and reset (already decided): one clock, clk_i; reset rst_i is synchronous and active-high.

Reset:
- All registered outputs are 0: a_o..d_o, all valids, m_valid_o, inflight_o, unexpected_o, mismatch_o.
- FIFO pointers and count clear.
- s_ready_o is 0 while rst_i is high.
- Reset mid-operation discards in-flight accounting. Any q_valid_i arriving after reset release with inflight==0 sets unexpected_o and is dropped.

Credit and issue:
- s_ready_o = (inflight + fifo_count < RES_DEPTH), computed from registered state only; it has no combinational path from s_valid_i or m_ready_i.
- Issue happens when s_valid_i && s_ready_o. Next cycle: a_o..d_o hold the captured operands and all four valids are 1 for exactly one cycle. The four valids are always equal.
- With no issue, valids are 0 and data outputs hold their last value.
- Issue-to-core latency: 1 cycle. Core q returns CORE_LATENCY cycles after the valids.
- Maximum throughput: one issue per cycle.

inflight counter:
- +1 on issue, -1 on q_valid_i while inflight>0.
- Simultaneous issue and return: unchanged.
- Saturation is impossible by construction.

Result FIFO:
- Depth RES_DEPTH, wrap-around pointers.
- Push on q_valid_i && inflight>0.
- Pop on m_valid_o && m_ready_i.
- m_valid_o = count>0. m_q_o = head entry, stable while m_valid_o && !m_ready_i.
- Simultaneous push and pop: count unchanged, allowed at full or empty. Push into empty FIFO: data visible the next cycle.

Sustained rate:
- Full throughput with m_ready_i held high requires RES_DEPTH >= CORE_LATENCY+2.
- The default of 8 sustains 1/cycle.

Arithmetic: the block does no arithmetic on the data path (passes operands and results through).

Optional Feature:
Macro CALC_ISSUER_CHECK_EN.
- Defined:
  - On issue, compute expected = ((a-b)*(3c+1) - (d<<2)) >>> 1, all in DATA_WIDTH signed wrap-around (truncate every intermediate to DATA_WIDTH).
  - Push expected into a RES_DEPTH-deep shadow queue.
  - On each accepted q_valid_i, pop the shadow queue and compare with q_i. On inequality, set mismatch_o (sticky until reset).
- Undefined: shadow queue and comparator are absent; mismatch_o = 0.

Decomposition:
Package calc_issuer_pkg holds:
- default DATA_WIDTH and RES_DEPTH constants;
- typedef operand_t (signed DATA_WIDTH);
- typedef operand_set_t (struct of a,b,c,d);
- function calc_expected() for check mode and the bench.

One sub-module, calc_issuer_fifo: parameterised sync FIFO (width, depth) with push/pop/count/full/empty. It is instantiated for results and, in check mode, for the shadow queue.

Test Plan:
1. Single op a=10,b=4,c=2,d=3, m_ready_i=1 -> core valids pulse 1 cycle after accept; m_q_o=15 with m_valid_o 1 cycle after q_valid_i; inflight_o returns to 0.
2. a=0,b=1,c=0,d=0 -> m_q_o=32'hFFFFFFFF (-1); a=32'h7FFFFFFF,b=-1,c=0,d=0 -> wrapped (a-b)=32'h80000000, result 32'hC0000000.
3. m_ready_i=0, continuous s_valid_i -> exactly 8 accepted, then s_ready_o=0; raise m_ready_i -> 8 results drain in issue order, one per cycle; issue resumes.
4. Back-to-back 20 ops with m_ready_i=1 -> s_ready_o never drops; results in order with no gaps.
5. Pulse q_valid_i with nothing in flight, and assert rst_i mid-stream -> unexpected_o=1, FIFO unchanged; all outputs 0 after reset; s_ready_o=0 during rst_i.
6. CALC_ISSUER_CHECK_EN defined: bench corrupts q_i on the third return -> mismatch_o rises the following cycle and stays 1 until rst_i.

Source files
------------

// File: rtl/calc_issuer_pkg.sv
// calc_issuer_pkg: shared constants, operand types and the reference arithmetic of the core
package calc_issuer_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_RES_DEPTH = 8;
  typedef logic signed [DEF_DATA_WIDTH-1:0] operand_t;
  typedef struct packed {
    operand_t a;
    operand_t b;
    operand_t c;
    operand_t d;
  } operand_set_t;
  // q = ((a-b)*(3c+1) - 4d) >>> 1 with every intermediate wrapped to the operand width
  function automatic operand_t calc_expected(input operand_set_t s);
    operand_t diff;
    operand_t scale;
    diff = s.a - s.b;
    scale = operand_t'(3) * s.c + operand_t'(1);
    return (diff * scale - (s.d <<< 2)) >>> 1;
  endfunction
endpackage

// File: rtl/calc_issuer_fifo.sv
// calc_issuer_fifo: synchronous wrap-around FIFO with registered count and combinational head
module calc_issuer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  // storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/calc_issuer.sv
// calc_issuer: credit-based operand issuer and in-order result collector; CALC_ISSUER_CHECK_EN adds a result checker
module calc_issuer
  import calc_issuer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RES_DEPTH = DEF_RES_DEPTH,
  parameter int CORE_LATENCY = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_valid_i,
  output logic                           s_ready_o,
  input  logic [DATA_WIDTH-1:0]          s_a_i,
  input  logic [DATA_WIDTH-1:0]          s_b_i,
  input  logic [DATA_WIDTH-1:0]          s_c_i,
  input  logic [DATA_WIDTH-1:0]          s_d_i,
  output logic [DATA_WIDTH-1:0]          a_o,
  output logic [DATA_WIDTH-1:0]          b_o,
  output logic [DATA_WIDTH-1:0]          c_o,
  output logic [DATA_WIDTH-1:0]          d_o,
  output logic                           a_valid_o,
  output logic                           b_valid_o,
  output logic                           c_valid_o,
  output logic                           d_valid_o,
  input  logic [DATA_WIDTH-1:0]          q_i,
  input  logic                           q_valid_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [DATA_WIDTH-1:0]          m_q_o,
  output logic [$clog2(RES_DEPTH+1)-1:0] inflight_o,
  output logic                           unexpected_o,
  output logic                           mismatch_o
);
  localparam int CW = $clog2(RES_DEPTH+1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(RES_DEPTH);
  if (RES_DEPTH < 2 || (RES_DEPTH & (RES_DEPTH - 1)) != 0 || CORE_LATENCY < 1) begin : g_bad_params
    $error("calc_issuer: RES_DEPTH must be a power of two >= 2 and CORE_LATENCY >= 1");
  end
  logic [CW-1:0] res_count;
  logic res_full, res_empty;
  logic [CW:0] credit_used;
  logic issue, accept, pop;
  assign credit_used = {1'b0, inflight_o} + {1'b0, res_count};
  assign s_ready_o = !rst_i && !res_full && credit_used < DEPTH_C;
  assign issue = s_valid_i && s_ready_o;
  assign accept = q_valid_i && inflight_o != '0;
  assign m_valid_o = !res_empty;
  assign pop = m_valid_o && m_ready_i;
  // issue register, in-flight credit count and sticky unexpected-return flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_o <= '0;
      b_o <= '0;
      c_o <= '0;
      d_o <= '0;
      a_valid_o <= 1'b0;
      b_valid_o <= 1'b0;
      c_valid_o <= 1'b0;
      d_valid_o <= 1'b0;
      inflight_o <= '0;
      unexpected_o <= 1'b0;
    end else begin
      a_valid_o <= issue;
      b_valid_o <= issue;
      c_valid_o <= issue;
      d_valid_o <= issue;
      if (issue) begin
        a_o <= s_a_i;
        b_o <= s_b_i;
        c_o <= s_c_i;
        d_o <= s_d_i;
      end
      inflight_o <= inflight_o + CW'(issue) - CW'(accept);
      unexpected_o <= unexpected_o | (q_valid_i && inflight_o == '0);
    end
  end
  calc_issuer_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(accept),
    .wdata(q_i),
    .pop(pop),
    .rdata(m_q_o),
    .count(res_count),
    .full(res_full),
    .empty(res_empty)
  );
`ifdef CALC_ISSUER_CHECK_EN
  logic [DATA_WIDTH-1:0] expected, shadow_head;
  logic [CW-1:0] shadow_count;
  logic shadow_full, shadow_empty;
  logic unused_shadow;
  assign expected = calc_expected(operand_set_t'{a: s_a_i, b: s_b_i, c: s_c_i, d: s_d_i});
  assign unused_shadow = &{1'b0, shadow_count, shadow_full};
  calc_issuer_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RES_DEPTH)) u_shadow_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(issue),
    .wdata(expected),
    .pop(accept),
    .rdata(shadow_head),
    .count(shadow_count),
    .full(shadow_full),
    .empty(shadow_empty)
  );
  // returned results are compared in order against the values predicted at issue
  always_ff @(posedge clk_i) begin
    if (rst_i) mismatch_o <= 1'b0;
    else if (accept && !shadow_empty && q_i != shadow_head) mismatch_o <= 1'b1;
  end
`else
  assign mismatch_o = 1'b0;
`endif
endmodule

// File: tb/tb_calc_issuer.sv
// tb_calc_issuer: randomized self-checking bench with a core model and a transaction-level scoreboard
module tb_calc_issuer;
  localparam int DW = 32;
  localparam int RD = 8;
  localparam int CL = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [DW-1:0] s_a = '0, s_b = '0, s_c = '0, s_d = '0;
  logic s_ready_o, a_valid_o, b_valid_o, c_valid_o, d_valid_o;
  logic [DW-1:0] a_o, b_o, c_o, d_o, q_i, m_q_o;
  logic q_valid_i, m_valid_o, unexpected_o, mismatch_o;
  logic [$clog2(RD+1)-1:0] inflight_o;
  bit pv [CL];
  logic [DW-1:0] pq [CL] = '{default: '0};
  logic inject = 1'b0;
  logic corrupt_en = 1'b0;
  logic corrupt;
  int corrupt_at = 0;
  int good_rets = 0;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] pops [$];
  int inflight_n = 0, fifo_n = 0, acc_cnt = 0;
  bit vld_n = 0, unexp_n = 0, mis_n = 0;
  logic [4*DW-1:0] last_ops = '0;

  always #5 clk = ~clk;

  calc_issuer dut (
    .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(s_ready_o),
    .s_a_i(s_a), .s_b_i(s_b), .s_c_i(s_c), .s_d_i(s_d),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o),
    .a_valid_o(a_valid_o), .b_valid_o(b_valid_o), .c_valid_o(c_valid_o), .d_valid_o(d_valid_o),
    .q_i(q_i), .q_valid_i(q_valid_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready),
    .m_q_o(m_q_o), .inflight_o(inflight_o), .unexpected_o(unexpected_o), .mismatch_o(mismatch_o)
  );

  function automatic logic [DW-1:0] ref_q(input logic [DW-1:0] a, b, c, d);
    longint p;
    int t;
    p = (longint'($signed(a)) - longint'($signed(b))) * (3 * longint'($signed(c)) + 1) - 4 * longint'($signed(d));
    t = p[31:0];
    return t >>> 1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  assign corrupt = corrupt_en && good_rets == corrupt_at;
  assign q_valid_i = pv[CL-1] | inject;
  assign q_i = pq[CL-1] ^ {{(DW-1){1'b0}}, corrupt};

  always @(posedge clk) begin
    pv[0] <= a_valid_o;
    pq[0] <= ref_q(a_o, b_o, c_o, d_o);
    for (int i = 1; i < CL; i++) begin
      pv[i] <= pv[i-1];
      pq[i] <= pq[i-1];
    end
  end

  always @(negedge clk) begin
    bit iss, pop, ret;
    if (rst) begin
      chk("rdy_in_rst", s_ready_o, 0);
      exp_q.delete();
      inflight_n = 0;
      fifo_n = 0;
      vld_n = 0;
      unexp_n = 0;
      mis_n = 0;
      last_ops = '0;
    end else begin
      chk("s_ready", s_ready_o, exp_q.size() < RD);
      chk("valids", {a_valid_o, b_valid_o, c_valid_o, d_valid_o}, {4{vld_n}});
      chk("ops", {a_o, b_o, c_o, d_o}, last_ops);
      chk("m_valid", m_valid_o, fifo_n > 0);
      chk("inflight", inflight_o, inflight_n);
      chk("unexpected", unexpected_o, unexp_n);
      chk("mismatch", mismatch_o, mis_n);
      iss = s_valid && exp_q.size() < RD;
      pop = m_ready && fifo_n > 0;
      ret = q_valid_i && inflight_n > 0;
      unexp_n |= q_valid_i && inflight_n == 0;
      if (ret && corrupt) begin
        exp_q[fifo_n] ^= 1;
        mis_n = 1;
      end
      if (pop) begin
        chk("m_q", m_q_o, exp_q[0]);
        pops.push_back(m_q_o);
        void'(exp_q.pop_front());
      end
      if (iss) begin
        exp_q.push_back(ref_q(s_a, s_b, s_c, s_d));
        last_ops = {s_a, s_b, s_c, s_d};
      end
      vld_n = iss;
      inflight_n += int'(iss) - int'(ret);
      fifo_n += int'(ret) - int'(pop);
      acc_cnt += int'(iss);
      good_rets += int'(ret);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    s_a = $urandom;
    s_b = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 50);
    s_c = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
    s_d = $urandom;
  endtask

  task automatic send(input logic [DW-1:0] a, b, c, d);
    bit ok;
    ok = 0;
    s_valid = 1;
    s_a = a;
    s_b = b;
    s_c = c;
    s_d = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready_o;
    end
    chk("send_wait", ok, 1);
    @(posedge clk);
    #1;
    s_valid = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ops"}, {a_o, b_o, c_o, d_o}, 0);
    chk({tag, "_vld"}, {a_valid_o, b_valid_o, c_valid_o, d_valid_o}, 0);
    chk({tag, "_mv"}, m_valid_o, 0);
    chk({tag, "_infl"}, inflight_o, 0);
    chk({tag, "_unexp"}, unexpected_o, 0);
    chk({tag, "_mism"}, mismatch_o, 0);
  endtask

  initial begin
    int a0, stalls;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("rst");
    chk("rst_rdy", s_ready_o, 0);
    @(posedge clk);
    #1;
    rst = 0;
    m_ready = 1;
    pops.delete();
    send(10, 4, 2, 3);
    cyc(8);
    chk("t1_n", pops.size(), 1);
    chk("t1_q", pops.size() > 0 ? pops[0] : 'x, 15);
    chk("t1_infl", inflight_o, 0);
    pops.delete();
    send(0, 1, 0, 0);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    cyc(8);
    chk("t2_n", pops.size(), 2);
    chk("t2_neg1", pops.size() > 0 ? pops[0] : 'x, 32'hFFFF_FFFF);
    chk("t2_wrap", pops.size() > 1 ? pops[1] : 'x, 32'hC000_0000);
    m_ready = 0;
    a0 = acc_cnt;
    repeat (15) begin
      s_valid = 1;
      rand_ops();
      cyc(1);
    end
    s_valid = 0;
    chk("t3_acc", acc_cnt - a0, RD);
    @(negedge clk);
    chk("t3_full_rdy", s_ready_o, 0);
    @(posedge clk);
    #1;
    pops.delete();
    m_ready = 1;
    cyc(RD);
    chk("t3_drain", pops.size(), RD);
    chk("t3_empty", m_valid_o, 0);
    chk("t3_resume", s_ready_o, 1);
    a0 = acc_cnt;
    stalls = 0;
    repeat (20) begin
      s_valid = 1;
      rand_ops();
      @(negedge clk);
      stalls += int'(!s_ready_o);
      cyc(1);
    end
    s_valid = 0;
    chk("t4_stalls", stalls, 0);
    chk("t4_acc", acc_cnt - a0, 20);
    cyc(10);
    repeat (400) begin
      s_valid = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 9) < 7;
      rand_ops();
      cyc(1);
    end
    s_valid = 0;
    m_ready = 1;
    cyc(20);
    chk("rand_drained", inflight_o, 0);
    inject = 1;
    cyc(1);
    inject = 0;
    @(negedge clk);
    chk("t5_unexp", unexpected_o, 1);
    chk("t5_fifo", m_valid_o, 0);
    @(posedge clk);
    #1;
    m_ready = 0;
    repeat (5) begin
      s_valid = 1;
      rand_ops();
      cyc(1);
    end
    rst = 1;
    @(negedge clk);
    chk("t5_rdy_rst", s_ready_o, 0);
    cyc(2);
    rst = 0;
    s_valid = 0;
    @(negedge clk);
    check_idle_zero("t5_post");
    cyc(6);
    chk("t5_stale", unexpected_o, 1);
    rst = 1;
    cyc(2);
    rst = 0;
    m_ready = 1;
`ifdef CALC_ISSUER_CHECK_EN
    corrupt_at = good_rets + 2;
    corrupt_en = 1;
    repeat (4) begin
      rand_ops();
      send(s_a, s_b, s_c, s_d);
    end
    cyc(10);
    corrupt_en = 0;
    chk("t6_mism", mismatch_o, 1);
    cyc(5);
    chk("t6_sticky", mismatch_o, 1);
    rst = 1;
    cyc(2);
    rst = 0;
    @(negedge clk);
    chk("t6_clear", mismatch_o, 0);
`endif
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
